instr_aligner: RTL and testbench
================================

Name: instr_aligner

Overview:
- Front-end prefetch/alignment buffer. It is the producing end of the instruction stream that feeds compress_decoder.
- Accepts word-aligned 32-bit fetch data and splits it into a halfword FIFO. Presents one instruction per handshake: 16-bit RVC or 32-bit, including 32-bit instructions that straddle two fetch words.
- Tracks each instruction's PC. Handles flush/redirect to halfword-aligned targets.

Parameters:
DEPTH, 2, number of 32-bit fetch words buffered (halfword capacity 2*DEPTH); legal values >= 2
BOOT_ADDR, 32'h0000_0000, PC after reset; bit0 must be 0

Ports:
clk  input  1  clock
rst_n  input  1  reset; one clock, synchronous, active-low
flush_i  input  1  redirect; highest priority
flush_pc_i  input  32  redirect target; bit0 ignored (treated 0), bit1 may be 1
fetch_valid_i  input  1  fetch word valid
fetch_ready_o  output  1  aligner can accept a fetch word
fetch_rdata_i  input  32  fetch word from sequential word-aligned addresses
instr_valid_o  output  1  instr_o holds a complete instruction
instr_ready_i  input  1  consumer (decode) accepts instruction
instr_o  output  32  instruction; RVC zero-extended in [31:16]
instr_pc_o  output  32  PC of instr_o
instr_is_compressed_o  output  1  instr_o[1:0] != 2'b11

Behaviour:
- Storage: halfword FIFO of 2*DEPTH entries, with registered count, head pointer and tail pointer.
- Registered state: pc_q and drop_half_q.
- Reset (rst_n=0 at clk edge):
  - count=0, pointers=0, pc_q=BOOT_ADDR, drop_half_q=0.
  - Resulting outputs: instr_valid_o=0, instr_o=32'h0, instr_is_compressed_o=0, instr_pc_o=BOOT_ADDR, fetch_ready_o=1.
- fetch_ready_o = (count <= 2*DEPTH-2):
  - Depends only on registered count; no combinational dependence on instr_ready_i.
  - Overflow is therefore impossible.
- Push (fetch_valid_i && fetch_ready_o && !flush_i):
  - drop_half_q=0: push low half, then high half; count+=2.
  - drop_half_q=1: push high half only; count+=1; clear drop_half_q.
- Head decode (combinational from FIFO head):
  - hw0[1:0]!=2'b11: compressed. complete when count>=1. instr_o={16'h0,hw0}.
  - otherwise: 32-bit. complete when count>=2. instr_o={hw1,hw0}.
- instr_valid_o = complete && !flush_i. instr_o=32'h0 and instr_is_compressed_o=0 whenever instr_valid_o=0.
- instr_pc_o = pc_q at all times.
- Pop (instr_valid_o && instr_ready_i):
  - head += 1 (compressed) or 2 (32-bit), modulo 2*DEPTH.
  - pc_q += 2 or 4, wrapping mod 2^32.
- Simultaneous push and pop: count_next = count + pushed − popped.
- Latency: a word accepted in cycle N is visible on instr_o in cycle N+1. No same-cycle bypass.
- Straddling 32-bit instruction with only its low half buffered: instr_valid_o=0 until the next word is pushed; pc_q holds.
- Flush (flush_i=1 at clk edge; overrides push and pop):
  - count=0, pointers=0.
  - pc_q={flush_pc_i[31:1],1'b0}.
  - drop_half_q=flush_pc_i[1].
  - A fetch word handshaked in the flush cycle is discarded.
  - A consumer handshake cannot occur in the flush cycle (instr_valid_o forced 0).
- Consecutive flushes: the last one wins.
- Reset outranks flush.
- No instruction-legality checking; compress_decoder owns that.

Test Plan:
- Reset, push 32'h0000_0013 → next cycle: instr_valid_o=1, instr_o=32'h0000_0013, compressed=0, instr_pc_o=0. After pop: instr_pc_o=4, instr_valid_o=0.
- Push 32'h4501_0505 with instr_ready_i=1 → instr_o=32'h0000_0505 @pc 0, then 32'h0000_4501 @pc 2. compressed=1 both; pc ends at 4.
- Straddle: push 32'h0093_4501, wait 3 cycles, then push 32'h0001_0010:
  - 32'h0000_4501 @pc 0.
  - instr_valid_o=0 while waiting.
  - 32'h0010_0093 @pc 2 the cycle after the second push.
  - 32'h0000_0001 @pc 6.
- Flush with flush_pc_i=32'h0000_0103, then push 32'hAAAA_0505 → low half dropped. instr_o=32'h0000_AAAA, compressed=1, instr_pc_o=32'h0000_0102.
- Backpressure, DEPTH=2, instr_ready_i=0:
  - push two words → fetch_ready_o=1 after the first, 0 after the second.
  - A third fetch_valid_i is not accepted.
  - Release instr_ready_i → instructions emerge in order; fetch_ready_o reasserts once count<=2.
- Flush asserted in the same cycle as fetch_valid_i=1 and instr_ready_i=1 with a valid head:
  - that cycle: instr_valid_o=0.
  - next cycle: pc_q=flush target, count=0, instr_valid_o=0.
  - The coincident word never appears on instr_o.

Source files
------------

// File: rtl/instr_aligner.sv
// Instruction alignment buffer: splits word-aligned fetch data into a halfword FIFO
// and presents one complete RVC or 32-bit instruction, with its PC, per handshake.
module instr_aligner #(
   parameter int unsigned DEPTH     = 2,
   parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush_i,
   input  logic [31:0] flush_pc_i,
   input  logic        fetch_valid_i,
   output logic        fetch_ready_o,
   input  logic [31:0] fetch_rdata_i,
   output logic        instr_valid_o,
   input  logic        instr_ready_i,
   output logic [31:0] instr_o,
   output logic [31:0] instr_pc_o,
   output logic        instr_is_compressed_o
);

   localparam int unsigned HW = 2 * DEPTH;
   localparam int unsigned PW = $clog2(HW);
   localparam int unsigned CW = $clog2(HW + 1);
   localparam logic [PW:0] HW_P = (PW + 1)'(HW);

   logic [15:0]   mem_q [HW];
   logic [15:0]   mem_d [HW];
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   pc_q, pc_d;
   logic          drop_half_q, drop_half_d;

   logic [15:0]   hw0, hw1;
   logic          is_comp, complete, push, pop;
   logic [CW-1:0] push_n, pop_n;
   logic          flush_pc_unused;

   // Pointer advance modulo HW; HW need not be a power of two.
   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p, input logic [1:0] n);
      logic [PW:0] s;
      s = {1'b0, p} + {{(PW-1){1'b0}}, n};
      if (s >= HW_P) s = s - HW_P;
      return s[PW-1:0];
   endfunction

   assign flush_pc_unused = flush_pc_i[0];

   assign hw0      = mem_q[head_q];
   assign hw1      = mem_q[wrap_inc(head_q, 2'd1)];
   assign is_comp  = (hw0[1:0] != 2'b11);
   assign complete = is_comp ? (count_q != '0) : (count_q >= CW'(2));

   assign instr_valid_o         = complete && !flush_i;
   assign instr_o               = !instr_valid_o ? 32'h0 : (is_comp ? {16'h0, hw0} : {hw1, hw0});
   assign instr_is_compressed_o = instr_valid_o && is_comp;
   assign instr_pc_o            = pc_q;

   // Registered-count-only ready: two free halfwords guarantee a whole word fits.
   assign fetch_ready_o = (count_q <= CW'(HW - 2));

   assign push   = fetch_valid_i && fetch_ready_o && !flush_i;
   assign pop    = instr_valid_o && instr_ready_i;
   assign push_n = !push ? '0 : (drop_half_q ? CW'(1) : CW'(2));
   assign pop_n  = !pop  ? '0 : (is_comp ? CW'(1) : CW'(2));

   always_comb begin
      mem_d       = mem_q;
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      pc_d        = pc_q;
      drop_half_d = drop_half_q;
      if (flush_i) begin
         head_d      = '0;
         tail_d      = '0;
         count_d     = '0;
         pc_d        = {flush_pc_i[31:1], 1'b0};
         drop_half_d = flush_pc_i[1];
      end else begin
         if (pop) begin
            head_d = wrap_inc(head_q, is_comp ? 2'd1 : 2'd2);
            pc_d   = pc_q + (is_comp ? 32'd2 : 32'd4);
         end
         if (push) begin
            if (drop_half_q) begin
               // Redirect landed on the upper halfword of this fetch word.
               mem_d[tail_q] = fetch_rdata_i[31:16];
               tail_d        = wrap_inc(tail_q, 2'd1);
               drop_half_d   = 1'b0;
            end else begin
               mem_d[tail_q]                    = fetch_rdata_i[15:0];
               mem_d[wrap_inc(tail_q, 2'd1)]    = fetch_rdata_i[31:16];
               tail_d                           = wrap_inc(tail_q, 2'd2);
            end
         end
         count_d = count_q + push_n - pop_n;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         pc_q        <= BOOT_ADDR;
         drop_half_q <= 1'b0;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         pc_q        <= pc_d;
         drop_half_q <= drop_half_d;
      end
   end

   // Storage needs no reset: contents are only observed below the count.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_instr_aligner.sv
// Bench for instr_aligner: directed scenarios plus randomized traffic against a
// halfword-queue reference model.
module tb_instr_aligner;

   localparam int          DEPTH = 2;
   localparam logic [31:0] BOOT  = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n, flush_i, fetch_valid_i, instr_ready_i;
   logic [31:0] flush_pc_i, fetch_rdata_i;
   logic        fetch_ready_o, instr_valid_o, instr_is_compressed_o;
   logic [31:0] instr_o, instr_pc_o;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model state
   logic [15:0] mq[$];
   logic [31:0] m_pc;
   bit          m_drop;

   instr_aligner #(.DEPTH(DEPTH), .BOOT_ADDR(BOOT)) dut (
      .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
      .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o), .fetch_rdata_i(fetch_rdata_i),
      .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i), .instr_o(instr_o),
      .instr_pc_o(instr_pc_o), .instr_is_compressed_o(instr_is_compressed_o)
   );

   always #5 clk = ~clk;

   function automatic logic [65:0] obs();
      return {instr_valid_o, instr_is_compressed_o, instr_o, instr_pc_o};
   endfunction

   function automatic bit m_comp();
      return mq.size() >= 1 && mq[0][1:0] != 2'b11;
   endfunction

   function automatic bit m_valid();
      if (flush_i) return 1'b0;
      if (mq.size() == 0) return 1'b0;
      return m_comp() || mq.size() >= 2;
   endfunction

   function automatic logic [65:0] m_obs();
      logic [31:0] ins;
      ins = 32'h0;
      if (m_valid()) ins = m_comp() ? {16'h0, mq[0]} : {mq[1], mq[0]};
      return {m_valid(), m_valid() && m_comp(), ins, m_pc};
   endfunction

   // Advance one clock; the model consumes the inputs present at the edge.
   task automatic tick();
      bit rdy, pop, push, c;
      rdy  = mq.size() <= 2 * DEPTH - 2;
      pop  = m_valid() && instr_ready_i;
      push = fetch_valid_i && rdy && !flush_i;
      c    = m_comp();
      if (!rst_n) begin
         mq.delete(); m_pc = BOOT; m_drop = 0;
      end else if (flush_i) begin
         mq.delete(); m_pc = {flush_pc_i[31:1], 1'b0}; m_drop = flush_pc_i[1];
      end else begin
         if (pop) begin
            void'(mq.pop_front());
            if (!c) void'(mq.pop_front());
            m_pc = m_pc + (c ? 32'd2 : 32'd4);
         end
         if (push) begin
            if (!m_drop) mq.push_back(fetch_rdata_i[15:0]);
            mq.push_back(fetch_rdata_i[31:16]);
            m_drop = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush_i = 0; fetch_valid_i = 0; instr_ready_i = 0; flush_pc_i = 0; fetch_rdata_i = 0;
   endtask

   task automatic do_reset();
      idle(); rst_n = 0; tick(); rst_n = 1; #1;
   endtask

   task automatic test_reset();
      logic [65:0] e;
      do_reset();
      e = {1'b0, 1'b0, 32'h0, BOOT};
      n_chk++; if (obs() !== e) $display("FAIL reset_out got=%h exp=%h", obs(), e); else n_pass++;
      n_chk++; if (fetch_ready_o !== 1'b1) $display("FAIL reset_fetch_ready got=%b exp=1", fetch_ready_o); else n_pass++;
   endtask

   task automatic test_single32();
      logic [65:0] e;
      fetch_valid_i = 1; fetch_rdata_i = 32'h0000_0013; #1; tick();
      fetch_valid_i = 0; #1;
      e = {1'b1, 1'b0, 32'h0000_0013, 32'h0};
      n_chk++; if (obs() !== e) $display("FAIL single32_out got=%h exp=%h", obs(), e); else n_pass++;
      instr_ready_i = 1; #1; tick(); instr_ready_i = 0; #1;
      e = {1'b0, 1'b0, 32'h0, 32'h4};
      n_chk++; if (obs() !== e) $display("FAIL single32_after_pop got=%h exp=%h", obs(), e); else n_pass++;
   endtask

   task automatic test_compressed_pair();
      logic [65:0] e;
      do_reset();
      instr_ready_i = 1; fetch_valid_i = 1; fetch_rdata_i = 32'h4501_0505; #1; tick();
      fetch_valid_i = 0; #1;
      e = {1'b1, 1'b1, 32'h0000_0505, 32'h0};
      n_chk++; if (obs() !== e) $display("FAIL rvc_first got=%h exp=%h", obs(), e); else n_pass++;
      tick();
      e = {1'b1, 1'b1, 32'h0000_4501, 32'h2};
      n_chk++; if (obs() !== e) $display("FAIL rvc_second got=%h exp=%h", obs(), e); else n_pass++;
      tick();
      e = {1'b0, 1'b0, 32'h0, 32'h4};
      n_chk++; if (obs() !== e) $display("FAIL rvc_end got=%h exp=%h", obs(), e); else n_pass++;
      instr_ready_i = 0;
   endtask

   task automatic test_straddle();
      logic [65:0] e;
      do_reset();
      fetch_valid_i = 1; fetch_rdata_i = 32'h0093_4501; #1; tick();
      fetch_valid_i = 0; instr_ready_i = 1; #1;
      e = {1'b1, 1'b1, 32'h0000_4501, 32'h0};
      n_chk++; if (obs() !== e) $display("FAIL straddle_rvc got=%h exp=%h", obs(), e); else n_pass++;
      tick();
      for (int i = 0; i < 3; i++) begin
         e = {1'b0, 1'b0, 32'h0, 32'h2};
         n_chk++; if (obs() !== e) $display("FAIL straddle_wait%0d got=%h exp=%h", i, obs(), e); else n_pass++;
         tick();
      end
      fetch_valid_i = 1; fetch_rdata_i = 32'h0001_0010; #1; tick();
      fetch_valid_i = 0; #1;
      e = {1'b1, 1'b0, 32'h0010_0093, 32'h2};
      n_chk++; if (obs() !== e) $display("FAIL straddle_32 got=%h exp=%h", obs(), e); else n_pass++;
      tick();
      e = {1'b1, 1'b1, 32'h0000_0001, 32'h6};
      n_chk++; if (obs() !== e) $display("FAIL straddle_tail got=%h exp=%h", obs(), e); else n_pass++;
      tick();
      e = {1'b0, 1'b0, 32'h0, 32'h8};
      n_chk++; if (obs() !== e) $display("FAIL straddle_end got=%h exp=%h", obs(), e); else n_pass++;
      instr_ready_i = 0;
   endtask

   task automatic test_flush_odd();
      logic [65:0] e;
      flush_i = 1; flush_pc_i = 32'h0000_0103; #1;
      n_chk++; if (instr_valid_o !== 1'b0) $display("FAIL flush_odd_valid got=%b exp=0", instr_valid_o); else n_pass++;
      tick();
      flush_i = 0; fetch_valid_i = 1; fetch_rdata_i = 32'hAAAA_0505; #1; tick();
      fetch_valid_i = 0; #1;
      e = {1'b1, 1'b1, 32'h0000_AAAA, 32'h0000_0102};
      n_chk++; if (obs() !== e) $display("FAIL flush_odd_out got=%h exp=%h", obs(), e); else n_pass++;
      instr_ready_i = 1; #1; tick(); instr_ready_i = 0; #1;
      e = {1'b0, 1'b0, 32'h0, 32'h0000_0104};
      n_chk++; if (obs() !== e) $display("FAIL flush_odd_end got=%h exp=%h", obs(), e); else n_pass++;
   endtask

   task automatic test_backpressure();
      logic [65:0] e;
      do_reset();
      fetch_valid_i = 1; fetch_rdata_i = 32'h0000_0013; #1; tick();
      n_chk++; if (fetch_ready_o !== 1'b1) $display("FAIL bp_ready1 got=%b exp=1", fetch_ready_o); else n_pass++;
      fetch_rdata_i = 32'h4501_0505; #1; tick();
      n_chk++; if (fetch_ready_o !== 1'b0) $display("FAIL bp_ready2 got=%b exp=0", fetch_ready_o); else n_pass++;
      fetch_rdata_i = 32'hDEAD_BEEF; #1; tick();
      fetch_valid_i = 0; #1;
      e = {1'b1, 1'b0, 32'h0000_0013, 32'h0};
      n_chk++; if (obs() !== e) $display("FAIL bp_hold got=%h exp=%h", obs(), e); else n_pass++;
      instr_ready_i = 1; #1; tick();
      e = {1'b1, 1'b1, 32'h0000_0505, 32'h4};
      n_chk++; if (obs() !== e) $display("FAIL bp_second got=%h exp=%h", obs(), e); else n_pass++;
      n_chk++; if (fetch_ready_o !== 1'b1) $display("FAIL bp_reready got=%b exp=1", fetch_ready_o); else n_pass++;
      tick();
      e = {1'b1, 1'b1, 32'h0000_4501, 32'h6};
      n_chk++; if (obs() !== e) $display("FAIL bp_third got=%h exp=%h", obs(), e); else n_pass++;
      tick();
      e = {1'b0, 1'b0, 32'h0, 32'h8};
      n_chk++; if (obs() !== e) $display("FAIL bp_drained got=%h exp=%h", obs(), e); else n_pass++;
      instr_ready_i = 0;
   endtask

   task automatic test_flush_coincident();
      logic [65:0] e;
      do_reset();
      fetch_valid_i = 1; fetch_rdata_i = 32'h0000_0013; #1; tick();
      flush_i = 1; flush_pc_i = 32'h0000_0200; fetch_rdata_i = 32'h0505_0505; instr_ready_i = 1; #1;
      e = {1'b0, 1'b0, 32'h0, 32'h0};
      n_chk++; if (obs() !== e) $display("FAIL flushc_same got=%h exp=%h", obs(), e); else n_pass++;
      tick();
      flush_i = 0; fetch_valid_i = 0; #1;
      for (int i = 0; i < 3; i++) begin
         e = {1'b0, 1'b0, 32'h0, 32'h0000_0200};
         n_chk++; if (obs() !== e) $display("FAIL flushc_after%0d got=%h exp=%h", i, obs(), e); else n_pass++;
         tick();
      end
      n_chk++; if (fetch_ready_o !== 1'b1) $display("FAIL flushc_ready got=%b exp=1", fetch_ready_o); else n_pass++;
      instr_ready_i = 0;
   endtask

   task automatic test_random();
      logic [65:0] e;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         flush_i       = ($urandom_range(0, 19) == 0);
         flush_pc_i    = $urandom;
         fetch_valid_i = $urandom_range(0, 2) != 0;
         fetch_rdata_i = $urandom;
         instr_ready_i = $urandom_range(0, 3) != 0;
         #1;
         e = m_obs();
         n_chk++; if (obs() !== e) $display("FAIL rand_out[%0d] got=%h exp=%h", i, obs(), e); else n_pass++;
         n_chk++;
         if (fetch_ready_o !== (mq.size() <= 2 * DEPTH - 2))
            $display("FAIL rand_fetch_ready[%0d] got=%b exp=%b", i, fetch_ready_o, mq.size() <= 2 * DEPTH - 2);
         else n_pass++;
         tick();
      end
      idle();
   endtask

   initial begin
      rst_n = 0; idle(); m_pc = BOOT; m_drop = 0;
      test_reset();
      test_single32();
      test_compressed_pair();
      test_straddle();
      test_flush_odd();
      test_backpressure();
      test_flush_coincident();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
